// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IKILL = 2'd2
  } pipe_state_e;

  localparam int DWAIT_TIMEOUT_DEF = 255;
  localparam int WAIT_CNT_W_DEF    = $clog2(DWAIT_TIMEOUT_DEF + 1);

  // Wait-counter width for an arbitrary timeout: wide enough to hold the timeout value.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Latency: count updates on the edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async clear), clr (sync clear, wins over inc), inc, count.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges hazard stall/redirect with imem/dmem waits into per-stage enable/flush.
// Latency: enables/flushes are combinational (same cycle); state, watchdog and counters update next edge.
// Backpressure: a dmem wait freezes F..M and bubbles W; an imem wait or load-use holds F/D and bubbles E.
// Ports: clk_i, rst_n_i; hazard_stall_i, pc_src_i, imem_ready_i, dmem_req_m_i, dmem_ready_i;
//        en_{f,d,e,m,w}_o, flush_{d,e,w}_o, err_timeout_o (sticky), stall_cnt_o/flush_cnt_o.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the two performance counters (else tied to 0).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DWAIT_TIMEOUT = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hazard_stall_i,
  input  logic             pc_src_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_m_i,
  input  logic             dmem_ready_i,
  output logic             en_f_o,
  output logic             en_d_o,
  output logic             en_e_o,
  output logic             en_m_o,
  output logic             en_w_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = wait_cnt_w(DWAIT_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(DWAIT_TIMEOUT - 1);

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic              dfreeze;
  logic              redirect;
  logic [WAIT_W-1:0] wait_cnt;

  assign dfreeze = dmem_req_m_i && !dmem_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    redirect  = 1'b0;
    en_f_o    = 1'b1;
    en_d_o    = 1'b1;
    en_e_o    = 1'b1;
    en_m_o    = 1'b1;
    en_w_o    = 1'b1;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    case (state)
      IKILL: begin
        // Wrong-path fetch outstanding: its returning word must never reach D.
        flush_d_o = 1'b1;
        if (dfreeze) begin
          {en_f_o, en_d_o, en_e_o, en_m_o} = 4'b0000;
          flush_w_o = 1'b1;
          state_nxt = imem_ready_i ? DWAIT : IKILL;
        end else begin
          en_f_o    = 1'b0;
          state_nxt = imem_ready_i ? RUN : IKILL;
        end
      end
      default: begin  // RUN and DWAIT share the priority chain
        if (dfreeze) begin
          // E is held, so a pending redirect/stall re-presents itself after the wait.
          {en_f_o, en_d_o, en_e_o, en_m_o} = 4'b0000;
          flush_w_o = 1'b1;
          state_nxt = DWAIT;
        end else if (pc_src_i) begin
          redirect  = 1'b1;
          flush_d_o = 1'b1;
          flush_e_o = 1'b1;
          state_nxt = imem_ready_i ? RUN : IKILL;
        end else if (hazard_stall_i || !imem_ready_i) begin
          en_f_o    = 1'b0;
          en_d_o    = 1'b0;
          flush_e_o = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
    // Held reset: keep every register frozen and bubbled.
    if (!rst_n_i) begin
      {en_f_o, en_d_o, en_e_o, en_m_o, en_w_o} = 5'b00000;
      {flush_d_o, flush_e_o, flush_w_o}        = 3'b111;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (!dfreeze),
    .inc   (dfreeze),
    .count (wait_cnt)
  );

  // Sets on the edge that brings the consecutive-freeze count to DWAIT_TIMEOUT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_timeout_o <= 1'b0;
    end else if (dfreeze && (wait_cnt >= TIMEOUT_M1)) begin
      err_timeout_o <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_any;
  assign stall_any = !(en_f_o && en_d_o && en_e_o && en_m_o);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (1'b0),
    .inc   (stall_any),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (1'b0),
    .inc   (redirect),
    .count (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus watchdog and reset-abort sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_ctrl;

  localparam int CNT_W = 16;
`ifdef PIPE_CTRL_PERF_EN
  localparam int EXP_STALL = 12;
  localparam int EXP_FLUSH = 4;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_FLUSH = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_stall = 1'b0;
  logic pc_src = 1'b0;
  logic imem_ready = 1'b1;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;
  logic en_f, en_d, en_e, en_m, en_w;
  logic flush_d, flush_e, flush_w;
  logic err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DWAIT_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .hazard_stall_i (hazard_stall),
    .pc_src_i       (pc_src),
    .imem_ready_i   (imem_ready),
    .dmem_req_m_i   (dmem_req),
    .dmem_ready_i   (dmem_ready),
    .en_f_o         (en_f),
    .en_d_o         (en_d),
    .en_e_o         (en_e),
    .en_m_o         (en_m),
    .en_w_o         (en_w),
    .flush_d_o      (flush_d),
    .flush_e_o      (flush_e),
    .flush_w_o      (flush_w),
    .err_timeout_o  (err_timeout),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w}
  assign outs = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w};

  typedef struct {
    logic       hz;
    logic       pc;
    logic       ir;
    logic       dq;
    logic       dr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hz, input logic pc, input logic ir, input logic dq, input logic dr);
    hazard_stall = hz;
    pc_src       = pc;
    imem_ready   = ir;
    dmem_req     = dq;
    dmem_ready   = dr;
  endtask

  initial begin
    //          hz    pc    ir    dq    dr    expected outputs
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_000}; // idle
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00111_010}; // load-use
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_110}; // redirect, fetch busy -> IKILL
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b01111_100}; // IKILL
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b01111_100};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b01111_100}; // stale word discarded
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_000}; // back in RUN
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00111_010}; // imem wait
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00001_001}; // dfreeze masks redirect
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00001_001};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00001_001};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00001_001};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b11111_110}; // ready: redirect applies
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b11111_000};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11111_110}; // redirect beats load-use
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00111_010};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_110}; // -> IKILL
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00001_101}; // freeze in IKILL, stay
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b00001_101}; // freeze in IKILL, ready -> DWAIT
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_000}; // DWAIT exits to RUN

    // Held reset
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #12;
    chk("reset_outs", 32'(outs), 32'(8'b00000_111));
    chk("reset_err", 32'(err_timeout), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].hz, vecs[i].pc, vecs[i].ir, vecs[i].dq, vecs[i].dr);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_err", i), 32'(err_timeout), 32'd0);
      if (i == 0) begin
        chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("idle_flush_cnt", 32'(flush_cnt), 32'd0);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("perf_stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));
    chk("perf_flush_cnt", 32'(flush_cnt), 32'(EXP_FLUSH));

    // Watchdog: 8 consecutive freeze cycles, then sticky across ready
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 8) chk("wdog_err_before", 32'(err_timeout), 32'd0);
      if (c == 9) begin
        chk("wdog_err_rise", 32'(err_timeout), 32'd1);
        chk("wdog_frozen_outs", 32'(outs), 32'(8'b00001_001));
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wdog_err_sticky", 32'(err_timeout), 32'd1);
    chk("wdog_ready_outs", 32'(outs), 32'(8'b11111_000));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("wdog_err_cleared", 32'(err_timeout), 32'd0);

    // Reset asserted mid-IKILL abandons the kill
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ikill_outs", 32'(outs), 32'(8'b01111_100));
    #1;
    rst_n = 1'b0;
    #1;
    chk("ikill_reset_outs", 32'(outs), 32'(8'b00000_111));
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_run", 32'(outs), 32'(8'b11111_000));
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("post_reset_no_kill", 32'(outs), 32'(8'b00111_010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
